int_flag_sequencer: RTL

//  Interrupt-entry/return sequencer for the RAT CPU, directly upstream of the C/Z flag block.
//  - Synchronises and edge-detects the external interrupt line.
//  - Owns the interrupt-enable (I) flag.
//  - Decides at instruction boundaries whether to take an interrupt.
//  - Generates the flag block controls: shadow load on entry; shadow restore (FLG_LD_SEL + C_LD/Z_LD) on RETIE.
//  - Control unit consumes INT_TAKE to vector the PC; the flag block consumes FLG_SHAD_LD, FLG_LD_SEL, RST_C_LD, RST_Z_LD.

---
 rtl/rat_int_pkg.sv | 13 +
 rtl/int_sync_edge.sv | 46 ++++
 rtl/int_flag_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rat_int_pkg.sv
// Shared types for the RAT CPU interrupt sequencer.
`timescale 1ns/1ps
package rat_int_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ENTER   = 2'd1,
        RESTORE = 2'd2
    } int_state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/int_sync_edge.sv
// INTR synchroniser with rising-edge or level detection; emits a one-cycle set pulse.
`timescale 1ns/1ps
module int_sync_edge
    import rat_int_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int EDGE_TRIG   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr,
    output logic set
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic [SYNC_STAGES:0]   fill_r;
    logic                   set_s;

    // fill_r tracks when the sync chain and edge register hold real samples, so a line
    // already high across reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= '0;
            edge_r <= 1'b0;
            fill_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], intr};
            edge_r <= sync_r[SYNC_STAGES-1];
            fill_r <= {fill_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Set event: qualified rising edge, or plain synchronised level.
    always_comb begin
        set_s = 1'b0;
        if (EDGE_TRIG != 0) begin
            set_s = fill_r[SYNC_STAGES] & sync_r[SYNC_STAGES-1] & ~edge_r;
        end else begin
            set_s = sync_r[SYNC_STAGES-1];
        end
    end

    assign set = set_s;

endmodule

// File: rtl/int_flag_sequencer.sv
// Interrupt entry/return sequencer: pending latch, I flag and the RUN/ENTER/RESTORE FSM
// that drives the C/Z flag block shadow load and restore strobes.
`timescale 1ns/1ps
module int_flag_sequencer
    import rat_int_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int EDGE_TRIG   = 1
) (
    input  logic clk,
    input  logic RST_N,
    input  logic INTR,
    input  logic INSTR_DONE,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic RETIE,
    output logic INT_TAKE,
    output logic FLG_SHAD_LD,
    output logic FLG_LD_SEL,
    output logic RST_C_LD,
    output logic RST_Z_LD,
    output logic I_FLAG,
    output logic INT_PENDING
);

    int_state_t state_r;
    int_state_t state_s;
    logic       pending_r;
    logic       i_flag_r;
    logic       set_s;

    int_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TRIG   (EDGE_TRIG)
    ) u_sync (
        .clk   (clk),
        .rst_n (RST_N),
        .intr  (INTR),
        .set   (set_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: RETIE wins over a pending interrupt at the same boundary.
    always_comb begin
        state_s = RUN;
        case (state_r)
            RUN: begin
                if (INSTR_DONE && RETIE) begin
                    state_s = RESTORE;
                end else if (INSTR_DONE && pending_r && i_flag_r) begin
                    state_s = ENTER;
                end else begin
                    state_s = RUN;
                end
            end
            ENTER:   state_s = RUN;
            RESTORE: state_s = RUN;
            default: state_s = RUN;
        endcase
    end

    // Moore strobes decoded from the state register only.
    always_comb begin
        INT_TAKE    = 1'b0;
        FLG_SHAD_LD = 1'b0;
        FLG_LD_SEL  = 1'b0;
        RST_C_LD    = 1'b0;
        RST_Z_LD    = 1'b0;
        case (state_r)
            ENTER: begin
                INT_TAKE    = 1'b1;
                FLG_SHAD_LD = 1'b1;
            end
            RESTORE: begin
                FLG_LD_SEL = 1'b1;
                RST_C_LD   = 1'b1;
                RST_Z_LD   = 1'b1;
            end
            default: begin
                INT_TAKE = 1'b0;
            end
        endcase
    end

    // Pending latch: a set event in the ENTER cycle keeps the request for the next boundary.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            pending_r <= 1'b0;
        end else if (set_s) begin
            pending_r <= 1'b1;
        end else if (state_r == ENTER) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // I flag: sequencer actions override SEI/CLI, and CLI beats SEI.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            i_flag_r <= 1'b0;
        end else if (state_r == ENTER) begin
            i_flag_r <= 1'b0;
        end else if (state_r == RESTORE) begin
            i_flag_r <= 1'b1;
        end else if (I_CLR) begin
            i_flag_r <= 1'b0;
        end else if (I_SET) begin
            i_flag_r <= 1'b1;
        end else begin
            i_flag_r <= i_flag_r;
        end
    end

    assign I_FLAG      = i_flag_r;
    assign INT_PENDING = pending_r;

endmodule
